uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
Oversampling UART receiver that is the receiving end for the team's 8N1 `uarttx`.
- Samples `rx` at OVS× the baud rate and validates the start bit at mid-bit.
- Samples each data bit at its centre, LSB first, and checks the stop bit.
- Delivers each byte with a one-cycle `done` strobe, or flags a framing error.
- Sits between the serial pin and the byte-level consumer logic.

Parameters:
- clk_freq, 1000000, system clock frequency in Hz.
- baud_rate, 9600, nominal line rate in bits/s.
- OVS, 8, oversample ticks per bit; must be even and ≥ 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; asynchronous to clk; idles high.
- rxdata  output  8  last good received byte.
- done  output  1  one-clk strobe: `rxdata` updated with a good frame.
- ferr  output  1  one-clk strobe: stop bit sampled low.
- busy  output  1  high from start-edge detect until frame end (any exit back to IDLE).

Behaviour:
- Reset is async active-high. Reset values:
  - `rxdata` = 8'h00, `done` = 0, `ferr` = 0, `busy` = 0.
  - State = IDLE; sync flops = 1; all counters = 0.
- Synchroniser: 2-flop synchroniser on `rx` gives `rx_s`; `rx_p` is `rx_s` delayed one clk.
- Tick generator:
  - DIV = clk_freq/(baud_rate*OVS), integer truncation; default 13.
  - Free-running counter 0..DIV-1; `tick` pulses for one clk when the counter = DIV-1.
  - Bit period = OVS*DIV = 104 clk at defaults.
  - Counter restarts at 0 on start-edge detect, so sample points align to the edge.
- State machine, states IDLE, START, DATA, STOP:
  - IDLE: falling edge (`rx_p`=1, `rx_s`=0) → START; clear tick counter and oversample count `os_cnt`; `busy`=1.
    - A line held low never re-triggers; a new rising then falling edge is required.
  - START: on the tick where `os_cnt` = OVS/2-1 (mid start bit):
    - `rx_s`=0 → DATA, with `os_cnt` and `bit_cnt` cleared.
    - `rx_s`=1 → IDLE; treated as a glitch, no strobes.
  - DATA: on the tick where `os_cnt` = OVS-1, shift `rx_s` into `shreg[7]` with a right shift, so bit 0 arrives first; `bit_cnt`++.
    - After the 8th sample → STOP.
  - STOP: on the tick where `os_cnt` = OVS-1:
    - `rx_s`=1 → `rxdata` <= `shreg`, `done`=1 for one clk.
    - `rx_s`=0 → `ferr`=1 for one clk; `rxdata` is held.
    - Either case → IDLE.
- `os_cnt` advances only on `tick` and wraps at OVS-1.
- `done` and `ferr` are mutually exclusive and never assert in the same clk as a start-edge detect.
- Latency: `done` rises about 9.5 bit periods + 3 clk after the start-bit falling edge on `rx`.
- Baud tolerance: accepts tx rates within ±3 % of baud_rate; the existing `uarttx` at ≈9434 bit/s is in range.
- Reset asserted mid-frame aborts immediately: no `done` or `ferr`; the next frame needs a fresh falling edge after release.
- Back-to-back frames: a start edge arriving in the clk after the STOP sample is detected normally.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples a 9th bit at mid-bit.
  - Even parity is checked over the 8 data bits.
  - Output `perr` (1 bit, reset 0) strobes one clk alongside the STOP decision if parity mismatched.
  - On mismatch, `done` is still suppressed and `rxdata` held.
- Undefined: no PARITY state, no `perr` port; 8N1 only.

Decomposition:
- Package `uart_pkg`:
  - `rx_state_t` enum {IDLE, START, DATA, STOP, PARITY}.
  - Localparam DATA_BITS = 8.
  - A function computing DIV from clk_freq/baud_rate/OVS.
- Sub-module `uart_baud_tick`: divider with synchronous restart input and a `tick` output; reusable by a future oversampling transmitter.

Test Plan:
- Reset, then 8N1 frame 8'hA5 at 9600 bit/s → `done`=1 for one clk; `rxdata`=8'hA5; `ferr`=0; `busy` falls the same clk.
- Drive `uarttx` with `dintx`=8'd64, `newd` pulse; loop its `tx` into `rx` → `done` with `rxdata`=8'd64.
- 30-clk low glitch on `rx` → return to IDLE; no `done`, no `ferr`; `busy` pulses only.
- Frame 8'h3C with stop bit forced low → `ferr`=1 for one clk; `rxdata` keeps the previous byte; no re-trigger while `rx` stays low.
- Back-to-back 8'h00 then 8'hFF with zero idle gap → two `done` strobes, `rxdata` 8'h00 then 8'hFF.
- Assert `rst` during the 4th data bit of 8'h55 → outputs at reset values; the next frame 8'h81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} rx_state_t;

  localparam int DATA_BITS = 8;

  function automatic int calc_div(input int clk_freq, input int baud_rate, input int ovs);
    return clk_freq / (baud_rate * ovs);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Serial-pin / byte-consumer signal bundle for uart_rx_os.
// perr exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_os_if;
  logic       rx;
  logic [7:0] rxdata;
  logic       done;
  logic       ferr;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       perr;

  modport master (output rx, input rxdata, input done, input ferr, input busy, input perr);
  modport slave  (input rx, output rxdata, output done, output ferr, output busy, output perr);
`else
  modport master (output rx, input rxdata, input done, input ferr, input busy);
  modport slave  (input rx, output rxdata, output done, output ferr, output busy);
`endif
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: counts 0..DIV-1, tick at DIV-1, synchronous restart to 0.
module uart_baud_tick #(
  parameter int DIV = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (restart || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver; define UART_RX_PARITY_EN for an even-parity bit and perr strobe.
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | counting to mid start bit, rejecting glitches
// DATA   | sampling 8 data bits at bit centres, LSB first
// PARITY | sampling the parity bit (parity build only)
// STOP   | sampling stop bit, issuing done / ferr
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600,
  parameter int OVS       = 8
) (
  input logic         clk,
  input logic         rst,
  uart_rx_os_if.slave bus
);

  localparam int DIV  = calc_div(clk_freq, baud_rate, OVS);
  localparam int OS_W = $clog2(OVS);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVS / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVS - 1);
  localparam logic [2:0]      BIT_LAST = 3'(DATA_BITS - 1);

  logic rx_meta_q, rx_s_q, rx_p_q;
  logic tick, restart, start_edge;

  rx_state_t           state_q, state_d;
  logic [OS_W-1:0]     os_cnt_q, os_cnt_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shreg_q, shreg_d;
  logic [7:0]          rxdata_q, rxdata_d;
  logic                done_q, done_d;
  logic                ferr_q, ferr_d;
  logic                busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                par_q, par_d;
  logic                perr_q, perr_d;
  logic                par_bad;
  assign par_bad = ^{shreg_q, par_q};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_p_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
      rx_p_q    <= rx_s_q;
    end
  end

  assign start_edge = rx_p_q & ~rx_s_q;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    rxdata_d  = rxdata_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    busy_d    = busy_q;
    restart   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif
    if (tick && state_q != IDLE) os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        // Edge needs rx_p high, so a line held low cannot re-trigger.
        if (start_edge) begin
          state_d  = START;
          os_cnt_d = '0;
          busy_d   = 1'b1;
          restart  = 1'b1;
        end
      end
      START: begin
        if (tick && os_cnt_q == OS_MID) begin
          if (!rx_s_q) begin
            state_d   = DATA;
            os_cnt_d  = '0;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      DATA: begin
        if (tick && os_cnt_q == OS_LAST) begin
          shreg_d   = {rx_s_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt_q == BIT_LAST) state_d = PARITY;
`else
          if (bit_cnt_q == BIT_LAST) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick && os_cnt_q == OS_LAST) begin
          par_d   = rx_s_q;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick && os_cnt_q == OS_LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
          perr_d = par_bad;
          if (rx_s_q && !par_bad) begin
`else
          if (rx_s_q) begin
`endif
            rxdata_d = shreg_q;
            done_d   = 1'b1;
          end
          if (!rx_s_q) ferr_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      rxdata_q  <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      rxdata_q  <= rxdata_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign bus.rxdata = rxdata_q;
  assign bus.done   = done_q;
  assign bus.ferr   = ferr_q;
  assign bus.busy   = busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.perr   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: serial frames driven on rx, expected strobes queued and checked by a monitor.
module tb_uart_rx_os;

  typedef struct packed {
    logic       is_ferr;
    logic [7:0] data;
  } exp_t;

  localparam int BIT_NOM = 104;  // 1 MHz / 9600 with 8x oversample, DIV 13
  localparam int BIT_TX  = 106;  // the existing transmitter at ~9434 bit/s

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic done_prev;
  exp_t exp_q[$];

  uart_rx_os_if bus ();

  uart_rx_os dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic bit_out(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int n);
    bit_out(1'b0, n);
    for (int i = 0; i < 8; i++) bit_out(d[i], n);
    bit_out(stop_bit, n);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_drained(input string tag);
    n_cmp++;
    assert (exp_q.size() === 0) else begin
      n_err++;
      $error("FAIL %s pending_strobes observed=%0d expected=0", tag, exp_q.size());
    end
  endtask

  // Strobe monitor: every done/ferr must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.done || bus.ferr) begin
        n_cmp++;
        assert (exp_q.size() > 0) else begin
          n_err++;
          $error("FAIL unexpected_strobe observed done=%0b ferr=%0b expected no strobe", bus.done, bus.ferr);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_cmp++;
          assert ({bus.ferr, bus.done} === (e.is_ferr ? 2'b10 : 2'b01)) else begin
            n_err++;
            $error("FAIL strobe_kind observed ferr,done=%02b expected=%02b", {bus.ferr, bus.done}, (e.is_ferr ? 2'b10 : 2'b01));
          end
          n_cmp++;
          assert (bus.rxdata === e.data) else begin
            n_err++;
            $error("FAIL rxdata observed=%02h expected=%02h", bus.rxdata, e.data);
          end
          n_cmp++;
          assert (bus.busy === 1'b0) else begin
            n_err++;
            $error("FAIL busy_at_strobe observed=%0b expected=0", bus.busy);
          end
        end
      end
      if (done_prev) begin
        n_cmp++;
        assert (bus.done === 1'b0) else begin
          n_err++;
          $error("FAIL done_width observed=%0b expected=0", bus.done);
        end
      end
      done_prev = bus.done;
    end else begin
      done_prev = 1'b0;
    end
  end

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    done_prev = 1'b0;
    rst       = 1'b1;
    bus.rx    = 1'b1;
    repeat (3) @(negedge clk);
    check_bit("rst_done", bus.done, 1'b0);
    check_bit("rst_ferr", bus.ferr, 1'b0);
    check_bit("rst_busy", bus.busy, 1'b0);
    n_cmp++;
    assert (bus.rxdata === 8'h00) else begin
      n_err++;
      $error("FAIL rst_rxdata observed=%02h expected=00", bus.rxdata);
    end
    rst = 1'b0;
    bit_out(1'b1, 20);

    // Nominal-rate frame
    exp_q.push_back('{1'b0, 8'hA5});
    send_frame(8'hA5, 1'b1, BIT_NOM);
    bit_out(1'b1, 60);
    check_drained("frame_a5");
    check_bit("idle_busy_a5", bus.busy, 1'b0);

    // Slightly slow transmitter
    exp_q.push_back('{1'b0, 8'd64});
    send_frame(8'd64, 1'b1, BIT_TX);
    bit_out(1'b1, 60);
    check_drained("frame_64_slow");

    // Short low glitch: busy pulses, no strobe
    bus.rx = 1'b0;
    repeat (10) @(negedge clk);
    check_bit("glitch_busy_high", bus.busy, 1'b1);
    repeat (20) @(negedge clk);
    bit_out(1'b1, 100);
    check_bit("glitch_busy_low", bus.busy, 1'b0);
    check_drained("glitch");

    // Framing error: rxdata keeps previous byte, held-low line must not re-trigger
    exp_q.push_back('{1'b1, 8'd64});
    send_frame(8'h3C, 1'b0, BIT_NOM);
    bit_out(1'b0, 20);
    check_bit("ferr_no_retrigger_a", bus.busy, 1'b0);
    bit_out(1'b0, 300);
    check_bit("ferr_no_retrigger_b", bus.busy, 1'b0);
    n_cmp++;
    assert (bus.rxdata === 8'd64) else begin
      n_err++;
      $error("FAIL ferr_rxdata_held observed=%02h expected=40", bus.rxdata);
    end
    bit_out(1'b1, 60);
    check_drained("frame_3c_ferr");

    // Back-to-back frames, zero idle gap
    exp_q.push_back('{1'b0, 8'h00});
    exp_q.push_back('{1'b0, 8'hFF});
    send_frame(8'h00, 1'b1, BIT_NOM);
    send_frame(8'hFF, 1'b1, BIT_NOM);
    bit_out(1'b1, 60);
    check_drained("back_to_back");

    // Reset during the 4th data bit of 8'h55
    bit_out(1'b0, BIT_NOM);
    bit_out(1'b1, BIT_NOM);
    bit_out(1'b0, BIT_NOM);
    bit_out(1'b1, BIT_NOM);
    bit_out(1'b0, BIT_NOM / 2);
    check_bit("pre_reset_busy", bus.busy, 1'b1);
    rst    = 1'b1;
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
    check_bit("midrst_busy", bus.busy, 1'b0);
    check_bit("midrst_done", bus.done, 1'b0);
    check_bit("midrst_ferr", bus.ferr, 1'b0);
    n_cmp++;
    assert (bus.rxdata === 8'h00) else begin
      n_err++;
      $error("FAIL midrst_rxdata observed=%02h expected=00", bus.rxdata);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bit_out(1'b1, 200);
    check_bit("post_rst_busy", bus.busy, 1'b0);
    check_drained("aborted_55");

    exp_q.push_back('{1'b0, 8'h81});
    send_frame(8'h81, 1'b1, BIT_NOM);
    bit_out(1'b1, 60);
    check_drained("frame_81");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
